// File: rtl/servo_pwm_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
// Build option: define SLEW_LIMIT_EN to limit per-frame position change to MAX_STEP.
package servo_pwm_pkg;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_PERIOD_CYCLES = 1_000_000;
  localparam int DEF_MIN_PULSE     = 75_000;
  localparam int DEF_MAX_PULSE     = 130_000;
  localparam int DEF_POS_W         = 8;
  localparam int DEF_POS_MAX       = 100;
  localparam int DEF_HOME_POS      = 50;
  localparam int DEF_MAX_STEP      = 2;

`ifdef SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Linear position-to-width map; floor division keeps both end points exact.
  function automatic int unsigned pos_to_width(input int unsigned p, input int unsigned min_p,
                                               input int unsigned max_p, input int unsigned pos_max);
    return min_p + ((max_p - min_p) * p) / pos_max;
  endfunction

  function automatic int unsigned slew_step(input int unsigned cur, input int unsigned snap,
                                            input int unsigned step);
    if (snap > cur) return (snap - cur <= step) ? snap : cur + step;
    return (cur - snap <= step) ? snap : cur - step;
  endfunction

endpackage

// File: rtl/servo_pwm_chan_upd.sv
// Shared per-scan update: next position and width for the scanned channel,
// plus the per-channel shadow width registers written during the scan.
module servo_pwm_chan_upd
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int POS_W     = DEF_POS_W,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MAX_PULSE = DEF_MAX_PULSE,
  parameter int POS_MAX   = DEF_POS_MAX,
  parameter int HOME_POS  = DEF_HOME_POS,
  parameter int MAX_STEP  = DEF_MAX_STEP,
  parameter int CH_W      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scan_en,
  input  logic [CH_W-1:0]          scan_idx,
  input  logic [POS_W-1:0]         cur_pos,
  input  logic [POS_W-1:0]         snap_pos,
  output logic [POS_W-1:0]         next_pos,
  output logic [NUM_CH-1:0][31:0]  shadow
);

  localparam logic [31:0] HOME_W = pos_to_width(HOME_POS, MIN_PULSE, MAX_PULSE, POS_MAX);

  logic [NUM_CH-1:0][31:0] shadow_q, shadow_d;
  logic [31:0]             width;

  always_comb begin
    next_pos = snap_pos;
    if (SLEW_EN) next_pos = POS_W'(slew_step(32'(cur_pos), 32'(snap_pos), MAX_STEP));
    width    = pos_to_width(32'(next_pos), MIN_PULSE, MAX_PULSE, POS_MAX);
    shadow_d = shadow_q;
    if (scan_en) shadow_d[scan_idx] = width;
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= {NUM_CH{HOME_W}};
    else     shadow_q <= shadow_d;
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// NUM_CH servo PWM outputs on one shared frame counter; widths change only at frame wrap.
// Build option: SLEW_LIMIT_EN (see servo_pwm_pkg) enables per-frame slew limiting.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int MIN_PULSE     = DEF_MIN_PULSE,
  parameter int MAX_PULSE     = DEF_MAX_PULSE,
  parameter int POS_W         = DEF_POS_W,
  parameter int POS_MAX       = DEF_POS_MAX,
  parameter int HOME_POS      = DEF_HOME_POS,
  parameter int MAX_STEP      = DEF_MAX_STEP,
  parameter int CH_W          = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick,
  output logic [NUM_CH-1:0] settled,
  output logic              err
);

  localparam logic [31:0]      LAST_CNT  = 32'(PERIOD_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_CLAMP = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_HOME  = POS_W'(HOME_POS);
  localparam logic [31:0]      HOME_W    = pos_to_width(HOME_POS, MIN_PULSE, MAX_PULSE, POS_MAX);

  logic [31:0]                   cnt_q, cnt_d;
  logic [NUM_CH-1:0][POS_W-1:0]  tgt_q, tgt_d, snap_q, snap_d, cur_q, cur_d;
  logic [NUM_CH-1:0][31:0]       active_q, active_d, shadow;
  logic [NUM_CH-1:0]             pwm_q, pwm_d, settled_q, settled_d;
  logic                          frame_tick_q, frame_tick_d, err_q, err_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          wrap, scan_en, hs, ch_bad, pos_bad;
  logic [CH_W-1:0]               scan_idx;
  logic [POS_W-1:0]              scan_cur, scan_snap, next_pos;

  always_comb begin
    wrap      = en && (cnt_q == LAST_CNT);
    scan_en   = en && (cnt_q < 32'(NUM_CH));
    scan_idx  = cnt_q[CH_W-1:0];
    scan_cur  = cur_q[scan_idx];
    scan_snap = snap_q[scan_idx];
    hs        = cmd_valid && cmd_ready_q;
    ch_bad    = 32'(cmd_ch) >= 32'(NUM_CH);
    pos_bad   = 32'(cmd_pos) > 32'(POS_MAX);
  end

  servo_pwm_chan_upd #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .MIN_PULSE(MIN_PULSE), .MAX_PULSE(MAX_PULSE),
    .POS_MAX(POS_MAX), .HOME_POS(HOME_POS), .MAX_STEP(MAX_STEP), .CH_W(CH_W)
  ) u_upd (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_idx(scan_idx),
    .cur_pos(scan_cur), .snap_pos(scan_snap), .next_pos(next_pos), .shadow(shadow)
  );

  always_comb begin
    cnt_d = '0;
    if (en && !wrap) cnt_d = cnt_q + 32'd1;
    tgt_d = tgt_q;
    if (hs && !ch_bad) tgt_d[cmd_ch] = pos_bad ? POS_CLAMP : cmd_pos;
    // A new error wins over a simultaneous clear.
    err_d        = (err_q && !err_clr) || (hs && (ch_bad || pos_bad));
    snap_d       = wrap ? tgt_q : snap_q;
    active_d     = wrap ? shadow : active_q;
    cur_d        = cur_q;
    if (scan_en) cur_d[scan_idx] = next_pos;
    frame_tick_d = wrap;
    cmd_ready_d  = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i]     = en && (cnt_q < active_q[i]);
      settled_d[i] = (cur_q[i] == snap_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      tgt_q        <= {NUM_CH{POS_HOME}};
      snap_q       <= {NUM_CH{POS_HOME}};
      cur_q        <= {NUM_CH{POS_HOME}};
      active_q     <= {NUM_CH{HOME_W}};
      pwm_q        <= '0;
      settled_q    <= '1;
      frame_tick_q <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      snap_q       <= snap_d;
      cur_q        <= cur_d;
      active_q     <= active_d;
      pwm_q        <= pwm_d;
      settled_q    <= settled_d;
      frame_tick_q <= frame_tick_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = frame_tick_q;
  assign settled    = settled_q;
  assign err        = err_q;
  assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: frame timing, latency, clamp/error, enable, reset.
// A second 3-channel instance exercises the out-of-range channel path.
module tb_servo_pwm_multi;

  localparam int PER = 200;
`ifdef SLEW_LIMIT_EN
  localparam int SETTLE_FR = 6;
`else
  localparam int SETTLE_FR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, en, cmd_valid, cmd_valid3, err_clr;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_pos;
  logic       cmd_ready, frame_tick, err;
  logic [3:0] pwm_out, settled;
  logic       cmd_ready3, frame_tick3, err3;
  logic [2:0] pwm3, settled3;

  int         checks = 0, failures = 0;
  int         hi[4], hi3[3], ft_cnt;
  logic [3:0] mid_settled;

  always #5 clk = ~clk;

  servo_pwm_multi #(.NUM_CH(4), .PERIOD_CYCLES(PER), .MIN_PULSE(20), .MAX_PULSE(120),
    .POS_W(8), .POS_MAX(100), .HOME_POS(50), .MAX_STEP(10)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .err_clr(err_clr), .pwm_out(pwm_out),
    .frame_tick(frame_tick), .settled(settled), .err(err));

  servo_pwm_multi #(.NUM_CH(3), .PERIOD_CYCLES(PER), .MIN_PULSE(20), .MAX_PULSE(120),
    .POS_W(8), .POS_MAX(100), .HOME_POS(50), .MAX_STEP(10)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .err_clr(1'b0), .pwm_out(pwm3),
    .frame_tick(frame_tick3), .settled(settled3), .err(err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] pos);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pos   = pos;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 3 * PER) begin
      tick();
      n++;
    end
    if (n >= 3 * PER) begin
      checks++; failures++;
      $display("FAIL wait_frame_tick: no tick within %0d cycles", 3 * PER);
    end
  endtask

  // Starts on a frame_tick cycle, ends on the next frame's tick cycle.
  task automatic measure_frame();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int c = 0; c < 3; c++) hi3[c] = 0;
    ft_cnt = 0;
    for (int k = 0; k < PER; k++) begin
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      for (int c = 0; c < 3; c++) hi3[c] += int'(pwm3[c]);
      if (k > 0 && frame_tick === 1'b1) ft_cnt++;
      if (k == PER / 2) mid_settled = settled;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_valid3 = 1'b0; err_clr = 1'b0;
    cmd_ch = '0; cmd_pos = '0;
    tick(); tick();
    checks++; if (pwm_out !== 4'h0) begin failures++; $display("FAIL reset_pwm: got %h want 0", pwm_out); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    checks++; if (settled !== 4'hF) begin failures++; $display("FAIL reset_settled: got %h want f", settled); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready); end
  endtask

  task automatic test_home();
    en = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_en: got %b want 1", cmd_ready); end
    wait_tick();
    measure_frame();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[c] !== 70) begin failures++; $display("FAIL home_width ch%0d: got %0d want 70", c, hi[c]); end
    end
    checks++; if (ft_cnt !== 0) begin failures++; $display("FAIL home_extra_tick: got %0d want 0", ft_cnt); end
    checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL home_tick_period: got %b want 1", frame_tick); end
    checks++; if (mid_settled !== 4'hF) begin failures++; $display("FAIL home_settled: got %h want f", mid_settled); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL home_err: got %b want 0", err); end
  endtask

  task automatic test_latency();
    wait_tick();
    send(2'd1, 8'd100);
    wait_tick();
    measure_frame();
    checks++; if (hi[1] !== 70) begin failures++; $display("FAIL lat_n1_ch1: got %0d want 70", hi[1]); end
    checks++; if (mid_settled !== 4'hF) begin failures++; $display("FAIL lat_n1_settled: got %h want f", mid_settled); end
    measure_frame();
    checks++; if (hi[1] !== 120) begin failures++; $display("FAIL lat_n2_ch1: got %0d want 120", hi[1]); end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) continue;
      checks++;
      if (hi[c] !== 70) begin failures++; $display("FAIL lat_other ch%0d: got %0d want 70", c, hi[c]); end
    end
  endtask

  task automatic test_slew();
    int   exp_w[6] = '{70, 60, 50, 40, 30, 20};
    logic exp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_tick();
    send(2'd0, 8'd0);
    wait_tick();
    for (int f = 0; f < 6; f++) begin
      measure_frame();
      checks++;
      if (hi[0] !== exp_w[f]) begin failures++; $display("FAIL slew_width f%0d: got %0d want %0d", f + 1, hi[0], exp_w[f]); end
      checks++;
      if (mid_settled[0] !== exp_s[f]) begin failures++; $display("FAIL slew_settled f%0d: got %b want %b", f + 1, mid_settled[0], exp_s[f]); end
    end
    checks++; if (hi[1] !== 70) begin failures++; $display("FAIL slew_other: got %0d want 70", hi[1]); end
  endtask

  task automatic test_err();
    int exp_w[4] = '{120, 70, 120, 120};
    do_reset();
    wait_tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_init: got %b want 0", err); end
    send(2'd2, 8'd250);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pos_clamp: got %b want 1", err); end
    cmd_ch = 2'd3; cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err_bad_ch: got %b want 1", err3); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clr: got %b want 0", err); end
    err_clr = 1'b1; send(2'd0, 8'd200); err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_clr_vs_new: got %b want 1", err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send(2'd0, 8'd10);
    send(2'd0, 8'd100);
    send(2'd3, 8'd100);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pos_max_ok: got %b want 0", err); end
    wait_tick();
    repeat (SETTLE_FR) measure_frame();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[c] !== exp_w[c]) begin failures++; $display("FAIL err_width ch%0d: got %0d want %0d", c, hi[c], exp_w[c]); end
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (hi3[c] !== 70) begin failures++; $display("FAIL bad_ch_dropped ch%0d: got %0d want 70", c, hi3[c]); end
    end
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL err3_sticky: got %b want 1", err3); end
  endtask

  task automatic test_enable();
    int bad = 0, ft_mid = 0;
    logic ft_last = 1'b0;
    do_reset();
    wait_tick();
    repeat (30) tick();
    checks++; if (pwm_out !== 4'hF) begin failures++; $display("FAIL en_pre_pwm: got %h want f", pwm_out); end
    en = 1'b0;
    tick();
    checks++; if (pwm_out !== 4'h0) begin failures++; $display("FAIL en_off_pwm: got %h want 0", pwm_out); end
    repeat (50) begin
      tick();
      if (pwm_out !== 4'h0 || frame_tick !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL en_off_hold: got %0d active cycles want 0", bad); end
    en = 1'b1;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int k = 0; k < PER; k++) begin
      tick();
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      if (k == PER - 1) ft_last = frame_tick;
      else if (frame_tick === 1'b1) ft_mid++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (hi[c] !== 70) begin failures++; $display("FAIL en_resume ch%0d: got %0d want 70", c, hi[c]); end
    end
    checks++; if (ft_mid !== 0) begin failures++; $display("FAIL en_resume_early_tick: got %0d want 0", ft_mid); end
    checks++; if (ft_last !== 1'b1) begin failures++; $display("FAIL en_resume_tick: got %b want 1", ft_last); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_tick();
    send(2'd1, 8'd0);
    wait_tick();
    repeat (50) tick();
    checks++; if (pwm_out !== 4'hF) begin failures++; $display("FAIL rmid_pre_pwm: got %h want f", pwm_out); end
    rst = 1'b1;
    tick();
    checks++; if (pwm_out !== 4'h0) begin failures++; $display("FAIL rmid_pwm: got %h want 0", pwm_out); end
    checks++; if (settled !== 4'hF) begin failures++; $display("FAIL rmid_settled: got %h want f", settled); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready: got %b want 0", cmd_ready); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL rmid_tick: got %b want 0", frame_tick); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_back: got %b want 1", cmd_ready); end
    wait_tick();
    for (int f = 0; f < 3; f++) begin
      measure_frame();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (hi[c] !== 70) begin failures++; $display("FAIL rmid_width f%0d ch%0d: got %0d want 70", f, c, hi[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_home();
`ifdef SLEW_LIMIT_EN
    test_slew();
`else
    test_latency();
`endif
    test_err();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
